keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
//  Parametrised ROWS x COLS matrix-keypad scanner with debounce on press and release.
//  Drives one-hot column strobes and samples the row inputs.
//  Emits a binary key code with a one-cycle valid strobe; feeds the encoder/SSD path.
//  Runs on the divided scan clock clock_new.
// PARAMETERS
//  ROWS         4   number of row inputs (>=2)
//  COLS         4   number of column strobes (>=2)
//  DEBOUNCE     4   consecutive stable samples required on press and on release (>=1)
//  REPEAT_DELAY 50  clocks held before first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_RATE  10  clocks between subsequent auto-repeats (KEYPAD_REPEAT_EN only)
//  CW (localparam) = $clog2(ROWS*COLS)
// PORTS
//  clock_new  in   1     scan clock, rising edge
//  reset      in   1     asynchronous, active-high
//  row_in     in   ROWS  row sense lines, 1 = contact on a strobed column
//  col_out    out  COLS  column strobes, registered
//  key_code   out  CW    row_idx*COLS + col_idx of last accepted key; held until next accept
//  key_valid  out  1     one-clock pulse per accepted key (and per repeat)
//  key_held   out  1     high while accepted key is down (states PRESSED and RELEASE)
// BEHAVIOUR
//  Reset (async): state=IDLE, col_out=all ones, key_code=0, key_valid=0, key_held=0.
//    Reset also clears all counters; reset mid-scan/mid-debounce aborts with no pulse.
//  All outputs registered; key_valid defaults to 0 each clock unless set below.
//  IDLE: col_out=all ones. |row_in -> SCAN, col idx c=0, col_out=one-hot(0).
//  SCAN(c): sample row_in.
//    Hit -> DEBOUNCE; capture col=c, row=row_in; cnt=0; keep col_out=one-hot(c).
//    No hit and c<COLS-1 -> c+1, col_out=one-hot(c+1).
//    No hit and c=COLS-1 -> IDLE, col_out=all ones (bounce/no key).
//  DEBOUNCE: row_in==captured row -> cnt+1. Mismatch (incl. 0) -> IDLE, no pulse.
//    On the edge where cnt reaches DEBOUNCE:
//      -> PRESSED; key_valid=1, key_code updated, col_out=all ones, key_held=1.
//  PRESSED: |row_in -> stay. Else -> RELEASE, rcnt=1.
//  RELEASE: !|row_in -> rcnt+1; |row_in -> rcnt=0 and stay.
//    When rcnt reaches DEBOUNCE -> IDLE, key_held=0.
//    A press during RELEASE never produces a second pulse.
//  Multiple row bits captured: row_idx = lowest set bit index.
//    A second key on another column during PRESSED is ignored (no rollover).
//  Latency: IDLE detect at edge 0, key in column k ->
//    hit sampled at edge k+1, key_valid high after edge k+1+DEBOUNCE for one clock.
//  Counters sized $clog2 of the largest terminal value +1; no wrap is reachable.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: typematic repeat in PRESSED.
//    hcnt counts held clocks; at REPEAT_DELAY, key_valid pulses with the same key_code.
//    Then one pulse every REPEAT_RATE clocks.
//    hcnt clears on entering PRESSED; repeat stops on leaving PRESSED.
//  Not defined: exactly one key_valid per debounced press; hcnt logic absent.
// TESTING
//  Key r2,c1 (code 9), held 20 clks, DEBOUNCE=4
//    -> one key_valid at edge 6, key_code=9, key_held until 4 clks after release.
//  Press c3 with a 2-clock bounce in DEBOUNCE
//    -> return to IDLE, no pulse; stable retry -> code r*4+3.
//  Glitch seen in IDLE, gone by SCAN
//    -> col_out 0001,0010,0100,1000 then 1111, no pulse.
//  Release bounce (row toggles back within 3 clks)
//    -> stays in RELEASE, no second key_valid.
//  Assert reset during DEBOUNCE and during PRESSED
//    -> col_out=1111, key_valid=0, key_held=0 immediately (async).
//  KEYPAD_REPEAT_EN, hold 80 clks, DELAY=50, RATE=10
//    -> pulses at accept, +50, +60, +70; code constant.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS matrix-keypad scanner: one-hot column strobes, press/release debounce, binary key code.
// Latency: key in column k detected at edge 0 gives key_valid after edge k+1+DEBOUNCE; all outputs registered.
// No backpressure: key_valid is a one-clock strobe. Auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    localparam int CW          = $clog2(ROWS*COLS)
) (
    input  logic            clock_new,
    input  logic            reset,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int CIW = $clog2(COLS);
    localparam int RIW = $clog2(ROWS);
    localparam int DBW = $clog2(DEBOUNCE + 1);

    if (ROWS < 2 || COLS < 2 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_matrix_scanner: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t          state, state_nxt;
    logic [CIW-1:0]  col_idx, col_idx_nxt;
    logic [ROWS-1:0] cap_row, cap_row_nxt;
    logic [DBW-1:0]  cnt, cnt_nxt;
    logic [DBW-1:0]  rcnt, rcnt_nxt;
    logic [COLS-1:0] col_out_nxt;
    logic [CW-1:0]   key_code_nxt;
    logic            key_valid_nxt;
    logic            key_held_nxt;
    logic [DBW-1:0]  cnt_inc;
    logic [DBW-1:0]  rcnt_inc;
    logic [CW-1:0]   cap_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [HW-1:0] hcnt_inc;
    logic          rep_phase, rep_phase_nxt;
    logic          rep_fire;
`endif

    function automatic logic [COLS-1:0] onehot(input logic [CIW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Several rows on one column resolve to the lowest row.
    function automatic logic [RIW-1:0] lowest_row(input logic [ROWS-1:0] v);
        lowest_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) lowest_row = RIW'(i);
        end
    endfunction

    assign cnt_inc  = cnt + DBW'(1);
    assign rcnt_inc = rcnt + DBW'(1);
    assign cap_code = CW'(lowest_row(cap_row)) * CW'(COLS) + CW'(col_idx);

`ifdef KEYPAD_REPEAT_EN
    assign hcnt_inc = hcnt + HW'(1);
    assign rep_fire = rep_phase ? (hcnt_inc == HW'(REPEAT_RATE)) : (hcnt_inc == HW'(REPEAT_DELAY));
`endif

    always_comb begin
        state_nxt     = state;
        col_idx_nxt   = col_idx;
        cap_row_nxt   = cap_row;
        cnt_nxt       = cnt;
        rcnt_nxt      = rcnt;
        col_out_nxt   = col_out;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
`ifdef KEYPAD_REPEAT_EN
        hcnt_nxt      = hcnt;
        rep_phase_nxt = rep_phase;
`endif
        case (state)
            ST_IDLE: begin
                col_out_nxt = '1;
                if (|row_in) begin
                    state_nxt   = ST_SCAN;
                    col_idx_nxt = '0;
                    col_out_nxt = onehot('0);
                end
            end
            ST_SCAN: begin
                if (|row_in) begin
                    state_nxt   = ST_DEBOUNCE;
                    cap_row_nxt = row_in;
                    cnt_nxt     = '0;
                end else if (col_idx == CIW'(COLS - 1)) begin
                    state_nxt   = ST_IDLE;
                    col_out_nxt = '1;
                end else begin
                    col_idx_nxt = col_idx + CIW'(1);
                    col_out_nxt = onehot(col_idx + CIW'(1));
                end
            end
            ST_DEBOUNCE: begin
                if (row_in != cap_row) begin
                    state_nxt   = ST_IDLE;
                    col_out_nxt = '1;
                    cnt_nxt     = '0;
                end else if (cnt_inc == DBW'(DEBOUNCE)) begin
                    state_nxt     = ST_PRESSED;
                    key_valid_nxt = 1'b1;
                    key_code_nxt  = cap_code;
                    key_held_nxt  = 1'b1;
                    col_out_nxt   = '1;
                    cnt_nxt       = '0;
`ifdef KEYPAD_REPEAT_EN
                    hcnt_nxt      = '0;
                    rep_phase_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_PRESSED: begin
                // All columns strobed: any key keeps the press alive, none starts a new one.
                if (|row_in) begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_fire) begin
                        key_valid_nxt = 1'b1;
                        hcnt_nxt      = '0;
                        rep_phase_nxt = 1'b1;
                    end else begin
                        hcnt_nxt = hcnt_inc;
                    end
`endif
                end else if (DEBOUNCE == 1) begin
                    state_nxt    = ST_IDLE;
                    key_held_nxt = 1'b0;
                end else begin
                    state_nxt = ST_RELEASE;
                    rcnt_nxt  = DBW'(1);
                end
            end
            ST_RELEASE: begin
                if (|row_in) begin
                    rcnt_nxt = '0;
                end else if (rcnt_inc == DBW'(DEBOUNCE)) begin
                    state_nxt    = ST_IDLE;
                    key_held_nxt = 1'b0;
                    rcnt_nxt     = '0;
                end else begin
                    rcnt_nxt = rcnt_inc;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                col_out_nxt  = '1;
                key_held_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_new or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            col_idx   <= '0;
            cap_row   <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            col_out   <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_idx_nxt;
            cap_row   <= cap_row_nxt;
            cnt       <= cnt_nxt;
            rcnt      <= rcnt_nxt;
            col_out   <= col_out_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clock_new or posedge reset) begin
        if (reset) begin
            hcnt      <= '0;
            rep_phase <= 1'b0;
        end else begin
            hcnt      <= hcnt_nxt;
            rep_phase <= rep_phase_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad contact model, randomized scenarios, scoreboard of key_valid events.
module tb_keypad_matrix_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DEB   = 4;
    localparam int RDLY  = 50;
    localparam int RRATE = 10;
    localparam int NK    = ROWS * COLS;
    localparam int CW    = $clog2(NK);

    logic            clock_new = 1'b0;
    logic            reset;
    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_out;
    logic [CW-1:0]   key_code;
    logic            key_valid;
    logic            key_held;

    logic [NK-1:0]   pressed;
    logic [ROWS-1:0] glitch_row;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_pass = 0;

    typedef struct {
        int code;
        int at;
    } exp_t;
    exp_t sb[$];

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .clock_new(clock_new),
        .reset(reset),
        .row_in(row_in),
        .col_out(col_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clock_new = ~clock_new;
    always @(posedge clock_new) cyc <= cyc + 1;

    // A closed switch connects its row to its column strobe.
    always_comb begin
        row_in = glitch_row;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && col_out[c]) row_in[r] = 1'b1;
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    function automatic logic [NK-1:0] key_bit(input int r, input int c);
        key_bit = '0;
        key_bit[r*COLS+c] = 1'b1;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock_new);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock_new);
            if (!reset && key_valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_key_valid", int'(key_code), -1);
                end else begin
                    e = sb.pop_front();
                    chk(int'(key_code) == e.code, "key_code", int'(key_code), e.code);
                    chk(cyc == e.at, "pulse_cycle", cyc, e.at);
                end
            end
        end
    end

    // Stable press from IDLE: code = lowest row of the lowest column holding a key.
    task automatic press_run(input logic [NK-1:0] keys, input int hold, input bit rollover, input bit rel_bounce);
        int c0, r0, t0, acc, rel;
        exp_t e;
        c0 = 0;
        r0 = 0;
        for (int c = COLS - 1; c >= 0; c--)
            for (int r = ROWS - 1; r >= 0; r--)
                if (keys[r*COLS+c]) begin
                    c0 = c;
                    r0 = r;
                end
        @(negedge clock_new);
        pressed = keys;
        t0  = cyc + 1;
        acc = t0 + c0 + 1 + DEB;
        rel = acc + hold + 1;
        e.code = r0 * COLS + c0;
        e.at   = acc;
        sb.push_back(e);
`ifdef KEYPAD_REPEAT_EN
        for (int p = acc + RDLY; p < rel; p += RRATE) begin
            e.at = p;
            sb.push_back(e);
        end
`endif
        wait_until(acc);
        chk(key_held == 1'b1, "held_after_accept", int'(key_held), 1);
        chk(col_out == '1, "col_after_accept", int'(col_out), (1 << COLS) - 1);
        if (rollover) pressed = pressed | key_bit($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
        wait_until(acc + hold);
        pressed = '0;
        if (rel_bounce) begin
            @(negedge clock_new);
            pressed = keys;
            @(negedge clock_new);
            pressed = '0;
            rel = cyc + 1;
            chk(key_held == 1'b1, "held_in_release_bounce", int'(key_held), 1);
        end
        wait_until(rel + DEB - 2);
        chk(key_held == 1'b1, "held_before_release_done", int'(key_held), 1);
        @(negedge clock_new);
        chk(key_held == 1'b0, "held_after_release", int'(key_held), 0);
        chk(col_out == '1, "col_after_release", int'(col_out), (1 << COLS) - 1);
        repeat (3) @(negedge clock_new);
    endtask

    task automatic bounce_debounce(input int r, input int c);
        int t0;
        @(negedge clock_new);
        pressed = key_bit(r, c);
        t0 = cyc + 1;
        wait_until(t0 + c + 2);
        pressed = '0;
        repeat (2) @(negedge clock_new);
        chk(col_out == '1, "col_after_db_bounce", int'(col_out), (1 << COLS) - 1);
        chk(key_held == 1'b0, "held_after_db_bounce", int'(key_held), 0);
        press_run(key_bit(r, c), $urandom_range(1, 10), 1'b0, 1'b0);
    endtask

    task automatic glitch_idle();
        logic [COLS-1:0] ex;
        @(negedge clock_new);
        glitch_row = ROWS'($urandom_range(1, (1 << ROWS) - 1));
        @(negedge clock_new);
        glitch_row = '0;
        for (int i = 0; i <= COLS; i++) begin
            if (i > 0) @(negedge clock_new);
            ex = '1;
            if (i < COLS) begin
                ex = '0;
                ex[i] = 1'b1;
            end
            chk(col_out == ex, "glitch_col_seq", int'(col_out), int'(ex));
        end
        repeat (2) @(negedge clock_new);
    endtask

    task automatic reset_mid(input int r, input int c, input bit in_pressed);
        int t0;
        exp_t e;
        @(negedge clock_new);
        pressed = key_bit(r, c);
        t0 = cyc + 1;
        if (in_pressed) begin
            e.code = r * COLS + c;
            e.at   = t0 + c + 1 + DEB;
            sb.push_back(e);
            wait_until(e.at);
        end else begin
            wait_until(t0 + c + 3);
        end
        #2 reset = 1'b1;
        #1;
        chk(col_out == '1, "reset_col", int'(col_out), (1 << COLS) - 1);
        chk(key_valid == 1'b0, "reset_valid", int'(key_valid), 0);
        chk(key_held == 1'b0, "reset_held", int'(key_held), 0);
        chk(key_code == '0, "reset_code", int'(key_code), 0);
        pressed = '0;
        @(negedge clock_new);
        reset = 1'b0;
        repeat (2) @(negedge clock_new);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [NK-1:0] keys;
        int hold;
        reset      = 1'b1;
        pressed    = '0;
        glitch_row = '0;
        repeat (2) @(negedge clock_new);
        chk(col_out == '1, "rst_col_out", int'(col_out), (1 << COLS) - 1);
        chk(key_code == '0, "rst_key_code", int'(key_code), 0);
        chk(key_valid == 1'b0, "rst_key_valid", int'(key_valid), 0);
        chk(key_held == 1'b0, "rst_key_held", int'(key_held), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock_new);

        press_run(key_bit(2, 1), 14, 1'b0, 1'b0);
        bounce_debounce($urandom_range(0, ROWS-1), COLS - 1);
        glitch_idle();
        press_run(key_bit($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1)), 8, 1'b0, 1'b1);
        press_run(key_bit(3, 2) | key_bit(1, 2), 5, 1'b0, 1'b0);
        reset_mid(1, 2, 1'b0);
        reset_mid(0, 3, 1'b1);
`ifdef KEYPAD_REPEAT_EN
        press_run(key_bit(1, 1), 75, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 30; t++) begin
            keys = key_bit($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
            if ($urandom_range(0, 9) < 3) keys = keys | key_bit($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
`ifdef KEYPAD_REPEAT_EN
            hold = $urandom_range(20, 90);
`else
            hold = $urandom_range(1, 20);
`endif
            case ($urandom_range(0, 4))
                0, 1:    press_run(keys, hold, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                2:       bounce_debounce($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
                3:       glitch_idle();
                default: reset_mid($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1), 1'($urandom_range(0, 1)));
            endcase
        end

        repeat (10) @(negedge clock_new);
        chk(sb.size() == 0, "missing_key_valid", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
